mem_port_arbiter: RTL and testbench

- Shares the single 32-bit memory port between two requesters: port 0 (instruction fetch) and port 1 (load/store unit).
- Drives the select line of the existing two-input 32-bit address/write-data multiplexers and sequences each access to completion.
- Round-robin arbitration prevents either requester from starving the other.
- A watchdog counter flags a memory that never answers.

---
 rtl/mem_port_arbiter_pkg.sv | 27 ++
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/multiplexer_2_inputs.sv | 12 +
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// State encoding, port indices and the round-robin pick used by the top.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LSU   = 1'b1;

    // On a tie the port that did not win last time goes next.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last_grant);
        logic pick;
        if (req0 && req1) begin
            pick = ~last_grant;
        end else if (req1) begin
            pick = PORT_LSU;
        end else begin
            pick = PORT_FETCH;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared memory port.
// master = arbiter view, slave = requesters plus memory (environment) view.
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req0;
    logic                  req1;
    logic [DATA_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  we0;
    logic                  we1;
    logic                  done0;
    logic                  done1;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
    logic                  mem_valid;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        input  req0, req1, addr0, addr1, wdata0, wdata1, we0, we1,
        input  mem_ready, mem_rdata,
        output done0, done1, rdata, err,
        output mem_valid, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        output req0, req1, addr0, addr1, wdata0, wdata1, we0, we1,
        output mem_ready, mem_rdata,
        input  done0, done1, rdata, err,
        input  mem_valid, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/multiplexer_2_inputs.sv
// Two-input bus multiplexer, out = sel ? in1 : in0.
// Combinational, zero latency; no flow control.
module multiplexer_2_inputs #(
    parameter int WIDTH = 32
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out
);
    assign out = sel ? in1 : in0;
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (port 0) and LSU (port 1).
// Latency: grant, >=1 BUSY cycle, DONE pulse (3 cycles min); memory stalls via mem_ready, watchdog aborts.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    // 2**CNT_WIDTH must exceed TIMEOUT_CYCLES
    parameter int CNT_WIDTH      = 8
) (
    input  logic               clk,
    input  logic               resetn,
    mem_port_arbiter_if.master bus
);

    // Watchdog value seen during the last permitted BUSY cycle.
    localparam logic [CNT_WIDTH-1:0] WDOG_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic                  sel_q, sel_d;
    logic                  last_grant_q, last_grant_d;
    logic [CNT_WIDTH-1:0]  wdog_q, wdog_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  grant;
    logic                  busy;
    logic                  in_done;
    logic                  sel_we;

    assign grant   = rr_pick(bus.req0, bus.req1, last_grant_q);
    assign busy    = (state_q == BUSY);
    assign in_done = (state_q == DONE);
    assign sel_we  = (sel_q == PORT_LSU) ? bus.we1 : bus.we0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            sel_q        <= PORT_FETCH;
            last_grant_q <= PORT_LSU;
            wdog_q       <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            wdog_q       <= wdog_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        wdog_d       = wdog_q;
        rdata_d      = rdata_q;
        err_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    sel_d        = grant;
                    last_grant_d = grant;
                    wdog_d       = '0;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                wdog_d = wdog_q + CNT_WIDTH'(1);
                // A response in the final watchdog cycle still counts as success.
                if (bus.mem_ready) begin
                    rdata_d = bus.mem_rdata;
                    state_d = DONE;
                end else if (wdog_q == WDOG_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    multiplexer_2_inputs #(.WIDTH(DATA_WIDTH)) u_addr_mux (
        .sel (sel_q),
        .in0 (bus.addr0),
        .in1 (bus.addr1),
        .out (bus.mem_addr)
    );

    multiplexer_2_inputs #(.WIDTH(DATA_WIDTH)) u_wdata_mux (
        .sel (sel_q),
        .in0 (bus.wdata0),
        .in1 (bus.wdata1),
        .out (bus.mem_wdata)
    );

    // Strobes decode straight from the state flop so reset drops them asynchronously.
    assign bus.mem_valid = busy;
    assign bus.mem_we    = busy & sel_we;
    assign bus.done0     = in_done & (sel_q == PORT_FETCH);
    assign bus.done1     = in_done & (sel_q == PORT_LSU);
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed accesses push expected responses,
// negedge monitors pop and compare done/rdata/err and the memory-side access.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int DW = 32;
    localparam int TO = 6;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
    } acc_t;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
        int          gap;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        int          len;
    } mem_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO),
        .CNT_WIDTH      (8)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    acc_t q0[$];
    acc_t q1[$];
    rsp_t rsp_q[$];
    mem_t mem_q[$];

    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    int   ref_cyc = 0;
    int   mem_lat = 1;
    logic stray   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEAD_BEEF : ~a;
    endfunction

    // Requesters hold req until their done, then present the next queued access; memory answers after mem_lat BUSY cycles.
    initial begin : driver
        int busy_cnt;
        busy_cnt = 0;
        bus.req0 = 0; bus.addr0 = '0; bus.wdata0 = '0; bus.we0 = 0;
        bus.req1 = 0; bus.addr1 = '0; bus.wdata1 = '0; bus.we1 = 0;
        bus.mem_ready = 0; bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.done0 && q0.size() > 0) q0.delete(0);
            if (bus.done1 && q1.size() > 0) q1.delete(0);
            if (q0.size() > 0) begin
                bus.req0 = 1; bus.addr0 = q0[0].addr; bus.wdata0 = q0[0].wdata; bus.we0 = q0[0].we;
            end else begin
                bus.req0 = 0; bus.addr0 = '0; bus.wdata0 = '0; bus.we0 = 0;
            end
            if (q1.size() > 0) begin
                bus.req1 = 1; bus.addr1 = q1[0].addr; bus.wdata1 = q1[0].wdata; bus.we1 = q1[0].we;
            end else begin
                bus.req1 = 0; bus.addr1 = '0; bus.wdata1 = '0; bus.we1 = 0;
            end
            if (bus.mem_valid) begin
                busy_cnt++;
                bus.mem_ready = (busy_cnt == mem_lat);
                bus.mem_rdata = bus.mem_ready ? rd_of(bus.mem_addr) : 32'h0BAD_0BAD;
            end else begin
                busy_cnt = 0;
                bus.mem_ready = stray;
                bus.mem_rdata = 32'h5555_AAAA;
            end
        end
    end

    initial begin : monitor
        mem_t cur;
        rsp_t e;
        logic mv_prev;
        mv_prev = 1'b0;
        cur = '{32'h0, 32'h0, 1'b0, -1};
        forever begin
            @(negedge clk);
            if (!resetn) begin
                mv_prev = 1'b0;
            end else begin
                if (bus.done0 || bus.done1) begin
                    chk("done_onehot", {31'b0, bus.done0 & bus.done1}, 32'h0);
                    if (rsp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_done: got done0=%b done1=%b, expected none", bus.done0, bus.done1);
                    end else begin
                        e = rsp_q.pop_front();
                        chk("rsp_port", {31'b0, bus.done1}, {31'b0, e.port});
                        chk("rsp_rdata", bus.rdata, e.rdata);
                        chk("rsp_err", {31'b0, bus.err}, {31'b0, e.err});
                        chk("rsp_gap", 32'(cyc - ref_cyc), 32'(e.gap));
                    end
                    ref_cyc = cyc;
                end else if (bus.err) begin
                    chk("err_without_done", {31'b0, bus.err}, 32'h0);
                end
                if (bus.mem_valid && !mv_prev) begin
                    if (mem_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_access: got addr %h, expected no access", bus.mem_addr);
                        cur = '{bus.mem_addr, bus.mem_wdata, bus.mem_we, -1};
                    end else begin
                        cur = mem_q.pop_front();
                        chk("mem_addr", bus.mem_addr, cur.addr);
                        chk("mem_wdata", bus.mem_wdata, cur.wdata);
                        chk("mem_we", {31'b0, bus.mem_we}, {31'b0, cur.we});
                    end
                    cur.len = (cur.len < 0) ? -1 : cur.len - 1;
                end else if (bus.mem_valid) begin
                    chk("mem_addr_stable", bus.mem_addr, cur.addr);
                    chk("mem_wdata_stable", bus.mem_wdata, cur.wdata);
                    chk("mem_we_stable", {31'b0, bus.mem_we}, {31'b0, cur.we});
                    if (cur.len >= 0) cur.len = cur.len - 1;
                end else if (mv_prev && cur.len >= 0) begin
                    chk("busy_length_left", 32'(cur.len), 32'h0);
                end
                if (!bus.mem_valid && (bus.we0 || bus.we1))
                    chk("mem_we_gated", {31'b0, bus.mem_we}, 32'h0);
                mv_prev = bus.mem_valid;
            end
        end
    end

    task automatic issue(input logic port, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic we, input logic [31:0] exp_rd, input logic exp_err,
                         input int gap, input int len);
        acc_t a;
        rsp_t r;
        mem_t m;
        a = '{addr, wdata, we};
        r = '{port, exp_rd, exp_err, gap};
        m = '{addr, wdata, we, len};
        if (port == PORT_LSU) q1.push_back(a);
        else                  q0.push_back(a);
        rsp_q.push_back(r);
        mem_q.push_back(m);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((q0.size() + q1.size() + rsp_q.size() + mem_q.size()) != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: got %0d responses outstanding, expected 0", rsp_q.size());
            q0.delete(); q1.delete(); rsp_q.delete(); mem_q.delete();
        end
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.mem_valid && n < budget);
        if (!bus.mem_valid) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_valid_timeout: got mem_valid=0, expected 1");
        end
        #1;
    endtask

    initial begin : global_guard
        #200000;
        $display("FAIL global_timeout: got no completion, expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin : stimulus
        repeat (3) @(negedge clk);
        chk("reset_done0", {31'b0, bus.done0}, 32'h0);
        chk("reset_done1", {31'b0, bus.done1}, 32'h0);
        chk("reset_err", {31'b0, bus.err}, 32'h0);
        chk("reset_mem_valid", {31'b0, bus.mem_valid}, 32'h0);
        chk("reset_mem_we", {31'b0, bus.mem_we}, 32'h0);
        chk("reset_rdata", bus.rdata, 32'h0);
        @(posedge clk);
        #2 resetn = 1'b1;
        @(posedge clk);
        #2;

        // Single read on port 0, memory answers in the first BUSY cycle.
        mem_lat = 1; ref_cyc = cyc;
        issue(PORT_FETCH, 32'h100, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 2, 1);
        wait_drain(50);

        // Write on port 1 held for five BUSY cycles.
        mem_lat = 5; ref_cyc = cyc;
        issue(PORT_LSU, 32'h200, 32'h1234_5678, 1'b1, 32'hFFFF_FDFF, 1'b0, 6, 5);
        wait_drain(50);

        // Memory never answers: abort after TO BUSY cycles.
        mem_lat = 0; ref_cyc = cyc;
        issue(PORT_FETCH, 32'h500, 32'h0, 1'b0, 32'h0, 1'b1, 7, 6);
        wait_drain(50);

        // Answer on the last watchdog cycle wins over the timeout.
        mem_lat = 6; ref_cyc = cyc;
        issue(PORT_LSU, 32'h600, 32'hA5A5_0001, 1'b0, 32'hFFFF_F9FF, 1'b0, 7, 6);
        wait_drain(50);

        // Port 1 arrives during port 0's access; stray mem_ready outside BUSY.
        stray = 1'b1; mem_lat = 3; ref_cyc = cyc;
        issue(PORT_FETCH, 32'h800, 32'h0, 1'b0, 32'hFFFF_F7FF, 1'b0, 4, 3);
        wait_valid(20);
        issue(PORT_LSU, 32'h900, 32'h0, 1'b0, 32'hFFFF_F6FF, 1'b0, 5, 3);
        wait_drain(60);
        repeat (3) @(posedge clk);
        #2 stray = 1'b0;

        // Reset in the middle of a port 0 access.
        mem_lat = 0;
        q0.push_back('{32'hA00, 32'h0, 1'b0});
        mem_q.push_back('{32'hA00, 32'h0, 1'b0, -1});
        wait_valid(20);
        repeat (2) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("rst_mem_valid_async", {31'b0, bus.mem_valid}, 32'h0);
        chk("rst_rdata_cleared", bus.rdata, 32'h0);
        chk("rst_no_done0", {31'b0, bus.done0}, 32'h0);
        q0.delete();
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;
        @(posedge clk);
        #2;

        // Continuous ties after reset alternate 0,1,0,1.
        mem_lat = 1; ref_cyc = cyc;
        issue(PORT_FETCH, 32'h300, 32'h0, 1'b0, 32'hFFFF_FCFF, 1'b0, 2, 1);
        issue(PORT_LSU,   32'h400, 32'h0, 1'b0, 32'hFFFF_FBFF, 1'b0, 3, 1);
        issue(PORT_FETCH, 32'h308, 32'h0, 1'b0, 32'hFFFF_FCF7, 1'b0, 3, 1);
        issue(PORT_LSU,   32'h408, 32'h0, 1'b0, 32'hFFFF_FBF7, 1'b0, 3, 1);
        wait_drain(80);

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
